// File: rtl/palram_if.sv
// Bus between the palette RAM controller and its three neighbours: the pixel pipeline, the 68k
// CPU port, and the pins of the two palette RAMs.
interface palram_if;
    logic        PAL_BANK;
    logic        VID_REQ;
    logic [11:0] VID_INDEX;
    logic [15:0] COLOR;
    logic        COLOR_VALID;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [11:0] CPU_ADDR;
    logic [15:0] CPU_WDATA;
    logic [15:0] CPU_RDATA;
    logic        CPU_ACK;
    logic [12:0] PAL_ADDR;
    logic [15:0] PAL_DOUT;
    logic        PAL_DOE;
    logic [15:0] PAL_DIN;
    logic        nPAL_CE;
    logic        nPAL_OE;
    logic        nPAL_WE;

    modport master (
        output PAL_BANK, VID_REQ, VID_INDEX, CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, PAL_DIN,
        input  COLOR, COLOR_VALID, CPU_RDATA, CPU_ACK, PAL_ADDR, PAL_DOUT, PAL_DOE,
               nPAL_CE, nPAL_OE, nPAL_WE
    );

    modport slave (
        input  PAL_BANK, VID_REQ, VID_INDEX, CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, PAL_DIN,
        output COLOR, COLOR_VALID, CPU_RDATA, CPU_ACK, PAL_ADDR, PAL_DOUT, PAL_DOE,
               nPAL_CE, nPAL_OE, nPAL_WE
    );
endinterface

// File: rtl/palram_ctrl.sv
// Palette RAM slot controller: one fixed-length slot per pixel, shared between video colour
// lookups (always first) and 68k reads/writes, driving the pins of the two 8-bit palette RAMs.
module palram_ctrl #(
    parameter int unsigned SLOT_LEN  = 4,
    parameter int unsigned SAMPLE_PH = 3,
    parameter int unsigned WE_START  = 1,
    parameter int unsigned WE_END    = 2
) (
    input logic     CLK_24M,
    input logic     RESET,
    palram_if.slave bus
);
    localparam int unsigned PhW = $clog2(SLOT_LEN);

    localparam logic [PhW-1:0] PhLast    = PhW'(SLOT_LEN - 1);
    localparam logic [PhW-1:0] PhSample  = PhW'(SAMPLE_PH);
    localparam logic [PhW-1:0] PhWeStart = PhW'(WE_START);
    localparam logic [PhW-1:0] PhWeEnd   = PhW'(WE_END);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StVrd  = 2'd1;
    localparam logic [1:0] StCrd  = 2'd2;
    localparam logic [1:0] StCwr  = 2'd3;

    logic [PhW-1:0] ph_q, ph_d;
    logic [1:0]     state_q, state_d;
    logic [12:0]    addr_q, addr_d;
    logic [15:0]    dout_q, dout_d;
    logic [15:0]    color_q, color_d;
    logic           color_valid_q, color_valid_d;
    logic [15:0]    rdata_q, rdata_d;
    logic           ack_q, ack_d;
    logic           ce_n_q, ce_n_d;
    logic           oe_n_q, oe_n_d;
    logic           we_n_q, we_n_d;
    logic           doe_q, doe_d;
    logic           cpu_slot;

    // A CPU slot that is just ending still has its ACK in flight; the requester cannot have
    // dropped CPU_REQ yet, so it must not win this arbitration.
    assign cpu_slot = (state_q == StCrd) || (state_q == StCwr);

    always_comb begin
        ph_d          = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
        state_d       = state_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        color_d       = color_q;
        rdata_d       = rdata_q;
        color_valid_d = 1'b0;
        ack_d         = 1'b0;

        if (ph_q == PhSample) begin
            if (state_q == StVrd) begin
                color_d       = bus.PAL_DIN;
                color_valid_d = 1'b1;
            end
            if (state_q == StCrd) begin
                rdata_d = bus.PAL_DIN;
                ack_d   = 1'b1;
            end
        end

        if (ph_q == PhLast) begin
            if (state_q == StCwr) begin
                ack_d = 1'b1;
            end
            if (bus.VID_REQ) begin
                state_d = StVrd;
                addr_d  = {bus.PAL_BANK, bus.VID_INDEX};
            end else if (bus.CPU_REQ && !cpu_slot) begin
                state_d = bus.CPU_WE ? StCwr : StCrd;
                addr_d  = {bus.PAL_BANK, bus.CPU_ADDR};
                if (bus.CPU_WE) begin
                    dout_d = bus.CPU_WDATA;
                end
            end else begin
                state_d = StIdle;
            end
        end

        // RAM pins are registered from the next state so they never glitch.
        ce_n_d = (state_d == StIdle);
        oe_n_d = !((state_d == StVrd) || (state_d == StCrd));
        we_n_d = !((state_d == StCwr) && (ph_d >= PhWeStart) && (ph_d <= PhWeEnd));
        doe_d  = (state_d == StCwr);
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            ph_q          <= '0;
            state_q       <= StIdle;
            addr_q        <= '0;
            dout_q        <= '0;
            color_q       <= '0;
            color_valid_q <= 1'b0;
            rdata_q       <= '0;
            ack_q         <= 1'b0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            doe_q         <= 1'b0;
        end else begin
            ph_q          <= ph_d;
            state_q       <= state_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            rdata_q       <= rdata_d;
            ack_q         <= ack_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            doe_q         <= doe_d;
        end
    end

    assign bus.PAL_ADDR    = addr_q;
    assign bus.PAL_DOUT    = dout_q;
    assign bus.PAL_DOE     = doe_q;
    assign bus.nPAL_CE     = ce_n_q;
    assign bus.nPAL_OE     = oe_n_q;
    assign bus.nPAL_WE     = we_n_q;
    assign bus.COLOR       = color_q;
    assign bus.COLOR_VALID = color_valid_q;
    assign bus.CPU_RDATA   = rdata_q;
    assign bus.CPU_ACK     = ack_q;
endmodule
